// File: rtl/instruction_queue_pkg.sv
// rtl/instruction_queue_pkg.sv - shared opcode constants and decode helpers for the instruction queue
package instruction_queue_pkg;

  localparam int INST_W = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // Control-transfer instructions that open a speculation window
  function automatic logic is_branch(input logic [INST_W-1:0] inst);
    return (inst[6:0] == OPC_BRANCH) || (inst[6:0] == OPC_JALR);
  endfunction

  // Branches and stores carry immediate bits in the rd field, not a destination
  function automatic logic has_no_rd(input logic [INST_W-1:0] inst);
    return (inst[6:0] == OPC_BRANCH) || (inst[6:0] == OPC_STORE);
  endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - fetch, issue and branch-resolution signals of the instruction queue
interface instruction_queue_if
  import instruction_queue_pkg::*;
#(
  parameter int BW_TAG = 4
);
  logic              i_fetch_valid;
  logic              o_fetch_ready;
  logic [INST_W-1:0] i_fetch_inst;
  logic              i_rs_ready;
  logic [BW_TAG-1:0] i_rs_tag;
  logic              o_iss_valid;
  logic [INST_W-1:0] o_iss_inst;
  logic [9:0]        o_iss_rs_flatten;
  logic [4:0]        o_iss_rd;
  logic [BW_TAG-1:0] o_iss_tag;
  logic              o_iss_speculation;
  logic              i_branch_valid;
  logic              i_branch_correct_prediction;

  // Queue side
  modport slave (
    input  i_fetch_valid, i_fetch_inst, i_rs_ready, i_rs_tag,
           i_branch_valid, i_branch_correct_prediction,
    output o_fetch_ready, o_iss_valid, o_iss_inst, o_iss_rs_flatten,
           o_iss_rd, o_iss_tag, o_iss_speculation
  );

  // Fetch / reservation-station / branch-unit side
  modport master (
    output i_fetch_valid, i_fetch_inst, i_rs_ready, i_rs_tag,
           i_branch_valid, i_branch_correct_prediction,
    input  o_fetch_ready, o_iss_valid, o_iss_inst, o_iss_rs_flatten,
           o_iss_rd, o_iss_tag, o_iss_speculation
  );
endinterface

// File: rtl/instruction_queue_iq_fifo.sv
// rtl/instruction_queue_iq_fifo.sv - circular instruction storage with head/tail pointers and flush clear
module iq_fifo
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = INST_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  // Next pointer/count; flush wins over any push/pop (caller gates them anyway)
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (i_push) tail_d = tail_q + AW'(1);
      if (i_pop)  head_d = head_q + AW'(1);
      if (i_push && !i_pop)      count_d = count_q + CW'(1);
      else if (i_pop && !i_push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is left unreset; stale words are unreachable once count is 0
  always_ff @(posedge clk) begin
    if (i_push) mem[tail_q] <= i_wdata;
  end

  assign o_rdata = mem[head_q];
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
endmodule

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - in-order instruction queue with single-branch speculation tracking
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int BW_TAG = 4
) (
  input logic                clk,
  input logic                rst_n,
  instruction_queue_if.slave iq
);
  logic              full, empty, flush, push, pop;
  logic              head_is_br, stall_br;
  logic              spec_q, spec_d;
  logic [INST_W-1:0] head_inst;
  logic [BW_TAG-1:0] tag_w;

  iq_fifo #(.DEPTH(DEPTH), .WIDTH(INST_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (flush),
    .i_wdata (iq.i_fetch_inst),
    .o_rdata (head_inst),
    .o_full  (full),
    .o_empty (empty)
  );

  // A resolution only matters while a branch is outstanding
  assign flush      = spec_q && iq.i_branch_valid && !iq.i_branch_correct_prediction;
  assign head_is_br = is_branch(head_inst);
  // Only one unresolved branch: a second one waits, even in its resolve cycle
  assign stall_br   = head_is_br && spec_q;

  assign push = iq.i_fetch_valid && iq.o_fetch_ready;
  assign pop  = iq.o_iss_valid;

  assign iq.o_fetch_ready    = !full && !flush;
  assign iq.o_iss_valid      = !empty && iq.i_rs_ready && !flush && !stall_br;
  assign iq.o_iss_inst       = head_inst;
  assign iq.o_iss_rs_flatten = {head_inst[24:20], head_inst[19:15]};
  assign iq.o_iss_rd         = has_no_rd(head_inst) ? 5'd0 : head_inst[11:7];
  assign tag_w               = iq.i_rs_tag;
  assign iq.o_iss_tag        = tag_w;
  assign iq.o_iss_speculation = spec_q;

  // Speculation window opens when a branch issues, closes on its resolution
  always_comb begin
    spec_d = spec_q;
    if (spec_q && iq.i_branch_valid)  spec_d = 1'b0;
    else if (pop && head_is_br)       spec_d = 1'b1;
  end

  // Speculation flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spec_q <= 1'b0;
    else        spec_q <= spec_d;
  end
endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed table-driven bench for instruction_queue
module tb_instruction_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  instruction_queue_if #(.BW_TAG(4)) iq ();

  instruction_queue #(.DEPTH(8), .BW_TAG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (iq.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] inst;
    logic        rr;
    logic [3:0]  tag;
    logic        bv;
    logic        bc;
    logic        e_ready;
    logic        e_valid;
    logic        e_spec;
    logic        chk_head;
    logic [31:0] e_inst;
    logic [9:0]  e_rs;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'd8, 7'b1100011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b010, 5'd4, 7'b0100011};
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  function automatic logic [31:0] seq_inst(input int k);
    return addi(5'(k + 1), 5'd0, 12'(k + 16));
  endfunction

  function automatic vec_t mk(input logic fv, input logic [31:0] inst, input logic rr, input logic [3:0] tag,
                              input logic bv, input logic bc, input logic er, input logic ev, input logic es,
                              input logic ch, input logic [31:0] ei, input logic [9:0] ers, input logic [4:0] erd);
    vec_t v;
    v.fv = fv; v.inst = inst; v.rr = rr; v.tag = tag; v.bv = bv; v.bc = bc;
    v.e_ready = er; v.e_valid = ev; v.e_spec = es; v.chk_head = ch;
    v.e_inst = ei; v.e_rs = ers; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] inst, input logic rr, input logic [3:0] tag,
                       input logic bv, input logic bc);
    iq.i_fetch_valid = fv;
    iq.i_fetch_inst  = inst;
    iq.i_rs_ready    = rr;
    iq.i_rs_tag      = tag;
    iq.i_branch_valid = bv;
    iq.i_branch_correct_prediction = bc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(iq.o_fetch_ready), 32'd1);
    chk("reset_valid", 32'(iq.o_iss_valid), 32'd0);
    chk("reset_spec", 32'(iq.o_iss_speculation), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Puts a branch in flight so spec_r=1 and the queue is empty
  task automatic open_spec();
    drive(1'b1, beq(5'd1, 5'd2), 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b1, 4'd1, 1'b0, 1'b0);
    #1;
    chk("open_spec_issue", 32'(iq.o_iss_valid), 32'd1);
    tick();
  endtask

  initial begin
    vecs[0]  = mk(0, 32'd0,          0, 4'd0, 0, 0, 1, 0, 0, 0, 32'd0,          10'd0,          5'd0);
    vecs[1]  = mk(1, beq(1, 2),      0, 4'd0, 0, 0, 1, 0, 0, 0, 32'd0,          10'd0,          5'd0);
    vecs[2]  = mk(1, add_i(5, 3, 4), 1, 4'd3, 0, 0, 1, 1, 0, 1, beq(1, 2),      {5'd2, 5'd1},   5'd0);
    vecs[3]  = mk(0, 32'd0,          1, 4'd5, 0, 0, 1, 1, 1, 1, add_i(5, 3, 4), {5'd4, 5'd3},   5'd5);
    vecs[4]  = mk(1, beq(6, 7),      0, 4'd0, 0, 0, 1, 0, 1, 0, 32'd0,          10'd0,          5'd0);
    vecs[5]  = mk(0, 32'd0,          1, 4'd1, 0, 0, 1, 0, 1, 1, beq(6, 7),      {5'd7, 5'd6},   5'd0);
    vecs[6]  = mk(0, 32'd0,          1, 4'd1, 1, 1, 1, 0, 1, 1, beq(6, 7),      {5'd7, 5'd6},   5'd0);
    vecs[7]  = mk(0, 32'd0,          1, 4'd2, 0, 0, 1, 1, 0, 1, beq(6, 7),      {5'd7, 5'd6},   5'd0);
    vecs[8]  = mk(1, sw(10, 11),     0, 4'd0, 0, 0, 1, 0, 1, 0, 32'd0,          10'd0,          5'd0);
    vecs[9]  = mk(0, 32'd0,          1, 4'd7, 0, 0, 1, 1, 1, 1, sw(10, 11),     {5'd11, 5'd10}, 5'd0);
    vecs[10] = mk(1, addi(3, 0, 9),  1, 4'd1, 1, 0, 0, 0, 1, 0, 32'd0,          10'd0,          5'd0);
    vecs[11] = mk(0, 32'd0,          1, 4'd1, 0, 0, 1, 0, 0, 0, 32'd0,          10'd0,          5'd0);
    vecs[12] = mk(1, addi(2, 1, 7),  0, 4'd0, 1, 0, 1, 0, 0, 0, 32'd0,          10'd0,          5'd0);
    vecs[13] = mk(0, 32'd0,          1, 4'd2, 0, 0, 1, 1, 0, 1, addi(2, 1, 7),  {5'd7, 5'd1},   5'd2);
    vecs[14] = mk(1, jalr(1, 5),     0, 4'd0, 0, 0, 1, 0, 0, 0, 32'd0,          10'd0,          5'd0);
    vecs[15] = mk(0, 32'd0,          1, 4'd4, 0, 0, 1, 1, 0, 1, jalr(1, 5),     {5'd0, 5'd5},   5'd1);
    vecs[16] = mk(1, add_i(9, 1, 2), 1, 4'd4, 0, 0, 1, 0, 1, 0, 32'd0,          10'd0,          5'd0);
    vecs[17] = mk(0, 32'd0,          1, 4'd6, 0, 0, 1, 1, 1, 1, add_i(9, 1, 2), {5'd2, 5'd1},   5'd9);
    vecs[18] = mk(0, 32'd0,          0, 4'd0, 1, 1, 1, 0, 1, 0, 32'd0,          10'd0,          5'd0);
    vecs[19] = mk(0, 32'd0,          0, 4'd0, 0, 0, 1, 0, 0, 0, 32'd0,          10'd0,          5'd0);

    do_reset();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].fv, vecs[i].inst, vecs[i].rr, vecs[i].tag, vecs[i].bv, vecs[i].bc);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(iq.o_fetch_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_valid", i), 32'(iq.o_iss_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_spec", i), 32'(iq.o_iss_speculation), 32'(vecs[i].e_spec));
      if (vecs[i].chk_head) begin
        chk($sformatf("v%0d_inst", i), iq.o_iss_inst, vecs[i].e_inst);
        chk($sformatf("v%0d_rs", i), 32'(iq.o_iss_rs_flatten), 32'(vecs[i].e_rs));
        chk($sformatf("v%0d_rd", i), 32'(iq.o_iss_rd), 32'(vecs[i].e_rd));
      end
      if (vecs[i].e_valid) chk($sformatf("v%0d_tag", i), 32'(iq.o_iss_tag), 32'(vecs[i].tag));
      tick();
    end

    // Fill to DEPTH with issue blocked, hold a 9th, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq_inst(i), 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      chk($sformatf("fill%0d_ready", i), 32'(iq.o_fetch_ready), 32'd1);
      chk($sformatf("fill%0d_valid", i), 32'(iq.o_iss_valid), 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, seq_inst(8), 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      chk($sformatf("full%0d_ready", i), 32'(iq.o_fetch_ready), 32'd0);
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      drive(k < 2, seq_inst(8), 1'b1, 4'd3, 1'b0, 1'b0);
      #1;
      chk($sformatf("drain%0d_ready", k), 32'(iq.o_fetch_ready), (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("drain%0d_valid", k), 32'(iq.o_iss_valid), 32'd1);
      chk($sformatf("drain%0d_inst", k), iq.o_iss_inst, seq_inst(k));
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 4'd3, 1'b0, 1'b0);
    #1;
    chk("drain_empty", 32'(iq.o_iss_valid), 32'd0);
    tick();

    // Steady push+pop at count=3
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, seq_inst(k), 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, seq_inst(k + 3), 1'b1, 4'd2, 1'b0, 1'b0);
      #1;
      chk($sformatf("pp%0d_valid", k), 32'(iq.o_iss_valid), 32'd1);
      chk($sformatf("pp%0d_ready", k), 32'(iq.o_fetch_ready), 32'd1);
      chk($sformatf("pp%0d_inst", k), iq.o_iss_inst, seq_inst(k));
      tick();
    end
    for (int k = 5; k < 8; k++) begin
      drive(1'b0, 32'd0, 1'b1, 4'd2, 1'b0, 1'b0);
      #1;
      chk($sformatf("pp%0d_valid", k), 32'(iq.o_iss_valid), 32'd1);
      chk($sformatf("pp%0d_inst", k), iq.o_iss_inst, seq_inst(k));
      tick();
    end
    #1;
    chk("pp_empty", 32'(iq.o_iss_valid), 32'd0);

    // Misprediction with 4 queued entries and fetch still offering
    do_reset();
    open_spec();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, seq_inst(k), 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, seq_inst(4), 1'b1, 4'd5, 1'b1, 1'b0);
    #1;
    chk("misp_ready", 32'(iq.o_fetch_ready), 32'd0);
    chk("misp_valid", 32'(iq.o_iss_valid), 32'd0);
    chk("misp_spec", 32'(iq.o_iss_speculation), 32'd1);
    tick();
    drive(1'b1, addi(5'd7, 5'd0, 12'd77), 1'b1, 4'd5, 1'b0, 1'b0);
    #1;
    chk("post_misp_valid", 32'(iq.o_iss_valid), 32'd0);
    chk("post_misp_spec", 32'(iq.o_iss_speculation), 32'd0);
    chk("post_misp_ready", 32'(iq.o_fetch_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    #1;
    chk("post_misp_refill_valid", 32'(iq.o_iss_valid), 32'd1);
    chk("post_misp_refill_inst", iq.o_iss_inst, addi(5'd7, 5'd0, 12'd77));
    tick();

    // Asynchronous reset with 5 entries and a branch in flight
    do_reset();
    open_spec();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, seq_inst(k), 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 4'd1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_valid", 32'(iq.o_iss_valid), 32'd1);
    chk("pre_rst_spec", 32'(iq.o_iss_speculation), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(iq.o_iss_valid), 32'd0);
    chk("arst_ready", 32'(iq.o_fetch_ready), 32'd1);
    chk("arst_spec", 32'(iq.o_iss_speculation), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(iq.o_iss_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter BW_TAG, 4, width of reservation-station tag; tag 0 means "no producer".
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_fetch_valid  input  1  fetch offers an instruction.
REQ-006 SHALL have port o_fetch_ready  output  1  queue accepts the offered instruction.
REQ-007 SHALL have port i_fetch_inst  input  32  RV32I instruction word.
REQ-008 SHALL have port i_rs_ready  input  1  a reservation station is free for the head instruction.
REQ-009 SHALL have port i_rs_tag  input  BW_TAG  tag of that free station, nonzero.
REQ-010 SHALL have port o_iss_valid  output  1  head instruction issues this cycle.
REQ-011 SHALL have port o_iss_inst  output  32  issued instruction word.
REQ-012 SHALL have port o_iss_rs_flatten  output  10  {rs2, rs1} register indices to register file.
REQ-013 SHALL have port o_iss_rd  output  5  destination index; 0 for branch/store opcodes.
REQ-014 SHALL have port o_iss_tag  output  BW_TAG  equals i_rs_tag.
REQ-015 SHALL have port o_iss_speculation  output  1  issued instruction lies behind an unresolved branch.
REQ-016 SHALL have ports i_branch_valid input 1 and i_branch_correct_prediction input 1: branch resolution.

Function
REQ-017 SHALL be a circular FIFO of DEPTH words with head/tail pointers of log2(DEPTH) bits wrapping DEPTH-1 to 0, and a count of log2(DEPTH)+1 bits.
REQ-018 SHALL assert o_fetch_ready = !full && !flush, flush = i_branch_valid && !i_branch_correct_prediction; no same-cycle bypass at full.
REQ-019 SHALL write i_fetch_inst at tail when i_fetch_valid && o_fetch_ready; simultaneous push and pop leaves count unchanged.
REQ-020 SHALL drive o_iss_valid combinationally = !empty && i_rs_ready && !flush && !stall_br; issue pops the head in that cycle.
REQ-021 SHALL set stall_br when head opcode is BRANCH (1100011) or JALR and spec_r=1 (at most one unresolved branch), including the cycle the branch resolves.
REQ-022 SHALL decode o_iss_rs_flatten = {inst[24:20], inst[19:15]}, o_iss_rd = inst[11:7] except 0 for BRANCH and STORE (0100011).
REQ-023 SHALL drive o_iss_speculation = spec_r; a branch itself issues with current spec_r (0 by REQ-021).
REQ-024 SHALL set spec_r next cycle when a BRANCH/JALR issues; SHALL clear spec_r next cycle on any i_branch_valid.
REQ-025 SHALL on flush empty the queue (count=0, head=tail=0) next cycle, discarding all entries; no push or issue in the flush cycle.
REQ-026 SHALL on correct prediction keep all entries; issue continues per REQ-020 in the same cycle.
REQ-027 SHALL ignore i_branch_valid when spec_r=0 (no state change).
REQ-028 SHALL hold o_iss_inst/rs/rd at head contents whenever !empty, regardless of o_iss_valid.

Reset
REQ-029 SHALL on rst_n low clear head, tail, count, spec_r to 0; o_fetch_ready=1, o_iss_valid=0 while empty.
REQ-030 SHALL not reset the entry storage; reset mid-operation drops all entries.

Structure
REQ-031 SHALL take opcode constants (BRANCH, JALR, STORE) from the shared Define package.
REQ-032 SHALL instantiate one sub-module, iq_fifo (storage, pointers, count, flush clear); decode and speculation logic stay in the top.

Verification
REQ-033 SHALL cover fill: push 8 ADDIs with i_rs_ready=0 -> o_fetch_ready=0 after 8th; 9th held; release -> issue in order, one per cycle.
REQ-034 SHALL cover push+pop at count=3 for 5 cycles -> count stays 3, issued order equals fetch order.
REQ-035 SHALL cover BEQ then ADD x5 -> BEQ issues spec=0, rd=0; ADD issues spec=1, rd=5, tag=i_rs_tag.
REQ-036 SHALL cover second BEQ at head while spec_r=1 -> o_iss_valid=0 until i_branch_valid, issues cycle after.
REQ-037 SHALL cover misprediction with 4 entries and i_fetch_valid=1 -> no issue or push that cycle, count=0 next cycle, spec_r=0.
REQ-038 SHALL cover rst_n asserted with 5 entries and spec_r=1 -> count=0, o_iss_valid=0, o_fetch_ready=1 immediately.
